ps2_receptor: RTL
=================

# ps2_receptor

Receives serial PS/2 keyboard frames (start, 8 data bits LSB-first, odd parity, stop) on the raw `ps2c`/`ps2d` lines and produces one scan-code byte per frame with a single-cycle valid tick. It is the stage directly upstream of the scan-code filter, which consumes `dout` as its `ps2_Rx` byte stream, including `8'hF0` break codes.

## Interface
- `FILTER_LEN`, default 8: consecutive equal samples required before the filtered `ps2c` changes level.
- `TIMEOUT_CYCLES`, default 50000: number of `Clk_R` cycles without a falling edge before an in-progress frame is abandoned.
- `Clk_R`  in  1  system clock; sole clock domain.
- `Reset_R`  in  1  synchronous, active-high reset.
- `ps2c`  in  1  raw PS/2 clock line; asynchronous.
- `ps2d`  in  1  raw PS/2 data line; asynchronous.
- `rx_en`  in  1  when high, a new frame may start; an in-progress frame is not affected.
- `dout`  out  8  last good scan code; held until the next good frame.
- `rx_done_tick`  out  1  one-cycle pulse when `dout` updates.
- `busy`  out  1  high while a frame is in progress (states DPS and LOAD).
- `parity_err`  out  1  one-cycle pulse on a rejected frame (see Configuration).

## Operation
- `ps2c` and `ps2d` each pass through a 2-FF synchronizer.
- Glitch filter on the synchronized `ps2c`:
  - `FILTER_LEN`-bit shift register.
  - Filtered level goes to 1 when the register is all ones and to 0 when it is all zeros; otherwise it holds.
  - `fall_edge` is asserted for one cycle on a filtered 1→0 transition.
- FSM states:
  - **IDLE**, `busy`=0. On `fall_edge` with `rx_en`=1 and synchronized `ps2d`=0 (start bit): clear `b`, set `n`=9, clear the timer, go to DPS. On `fall_edge` with `ps2d`=1: ignore and stay in IDLE.
  - **DPS**. On each `fall_edge`: `b <= {ps2d, b[9:1]}` and clear the timer. If `n`==0, go to LOAD; otherwise `n <= n-1`. Without a `fall_edge`, the timer increments. If the timer reaches `TIMEOUT_CYCLES`, go to IDLE with no tick and no error.
  - **LOAD** (one cycle). Frame fields: `b[9]`=stop, `b[8]`=parity, `b[7:0]`=data. The frame is good when stop==1 and the parity check passes (see Configuration). Good frame: `dout <= b[7:0]`, pulse `rx_done_tick`. Bad frame: pulse `parity_err`, leave `dout` unchanged. Next state is IDLE.
- Widths:
  - `b`: 10 bits.
  - `n`: 4 bits.
  - Timer: `$clog2(TIMEOUT_CYCLES+1)` bits; saturation is not needed because reaching the limit exits DPS.
- Boundary conditions:
  - `rx_en` falling mid-frame: the frame completes normally.
  - `fall_edge` in the LOAD cycle: ignored. A 10–16.7 kHz PS/2 clock cannot produce this.
  - Back-to-back frames: each frame produces its own tick.

## Timing
- Reset values: state IDLE, `dout`=8'h00, `rx_done_tick`=0, `parity_err`=0, `busy`=0, synchronizers and filter all ones (idle-high line).
- Reset asserted mid-frame: the partial frame is discarded and the block is in IDLE on the next cycle.
- Edge latency: a `ps2c` fall produces `fall_edge` 2 + `FILTER_LEN` cycles later (±1).
- `ps2d` is sampled in the same cycle as `fall_edge`; the 2-FF delay on `ps2d` matches the clock path closely enough at PS/2 rates.
- `rx_done_tick` and `dout` update in the cycle after the `fall_edge` that sampled the stop bit (LOAD registers the outputs, which are visible on the following edge).
- `rx_done_tick` is never high for two consecutive cycles.

## Configuration
- `PS2_PARITY_CHECK_EN` defined:
  - A frame is good only if `^b[8:0]`==1 (odd parity) and stop==1.
  - A failing frame pulses `parity_err` and produces no tick.
- `PS2_PARITY_CHECK_EN` undefined:
  - The parity bit is ignored; only stop==1 is required.
  - `parity_err` pulses only on a stop-bit failure.

## Structure
- Shared package `ps2_pkg`:
  - FSM state enum: IDLE, DPS, LOAD.
  - `PS2_FRAME_BITS`=11.
  - `PS2_BREAK_CODE`=8'hF0, also used by the downstream filter.
- Sub-module `ps2_clk_filtro`: the synchronizers, glitch filter and `fall_edge` generation. Outputs are `fall_edge` and synchronized `ps2d`.

## Test plan
- Frame with data 8'h1C, parity 0, stop 1, `rx_en`=1 → one `rx_done_tick`, `dout`=8'h1C, `busy` low afterwards.
- Sequence 8'hF0 (parity 1) then 8'h1C → two ticks, `dout` = 8'hF0 then 8'h1C.
- 8'h1C sent with parity 1:
  - With `PS2_PARITY_CHECK_EN`: `parity_err` pulse, no tick, `dout` unchanged.
  - Without it: tick, `dout`=8'h1C.
- 3-cycle low glitch on `ps2c` with `FILTER_LEN`=8 in IDLE → no `fall_edge`; `busy` stays 0.
- Five bits of a frame, then a stall longer than `TIMEOUT_CYCLES` → back to IDLE with no tick; next full frame 8'h29 → tick, `dout`=8'h29.
- `Reset_R` pulsed after six bits → IDLE, `dout`=8'h00; next frame 8'h5A → tick, `dout`=8'h5A.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 receive path and the downstream scan-code
// filter: receiver FSM state encoding, frame geometry, the break code, and
// the frame-acceptance rule.
//
// Build option:
//   PS2_PARITY_CHECK_EN  defined   -> a frame needs stop==1 and odd parity.
//                        undefined -> parity bit ignored, only stop==1.
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DPS,
        LOAD
    } ps2_state_t;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    // Break prefix, also decoded by the scan-code filter.
    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

    // b holds {stop, parity, data[7:0]} once the start bit is dropped.
    function automatic logic ps2_frame_ok(input logic [PS2_FRAME_BITS-2:0] b);
`ifdef PS2_PARITY_CHECK_EN
        return b[9] & (^b[8:0]);
`else
        return b[9];
`endif
    endfunction

endpackage

// File: rtl/ps2_receptor_if.sv
// ---------------------------------------------------------------------------
// ps2_receptor_if
// Byte-stream side of the PS/2 receiver.
//   rx_en         receive enable (consumer -> receiver)
//   dout          last good scan code
//   rx_done_tick  one-cycle pulse when dout updates
//   busy          frame in progress
//   parity_err    one-cycle pulse on a rejected frame
// Modports: master = receiver, slave = consumer.
// ---------------------------------------------------------------------------
interface ps2_receptor_if;

    logic       rx_en;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       busy;
    logic       parity_err;

    modport master (
        input  rx_en,
        output dout,
        output rx_done_tick,
        output busy,
        output parity_err
    );

    modport slave (
        output rx_en,
        input  dout,
        input  rx_done_tick,
        input  busy,
        input  parity_err
    );

endinterface

// File: rtl/ps2_clk_filtro.sv
// ---------------------------------------------------------------------------
// ps2_clk_filtro
// Brings the raw PS/2 lines into the Clk_R domain and deglitches the clock.
//   Clk_R      system clock
//   Reset_R    synchronous active-high reset (lines assumed idle high)
//   ps2c       raw PS/2 clock, asynchronous
//   ps2d       raw PS/2 data, asynchronous
//   fall_edge  one-cycle pulse on a filtered 1->0 of ps2c
//   ps2d_sync  ps2d after a 2-FF synchronizer
// The filtered level only moves once FILTER_LEN consecutive samples agree,
// so short glitches on the clock line never produce an edge.
// ---------------------------------------------------------------------------
module ps2_clk_filtro #(
    parameter int FILTER_LEN = 8
) (
    input  logic Clk_R,
    input  logic Reset_R,
    input  logic ps2c,
    input  logic ps2d,
    output logic fall_edge,
    output logic ps2d_sync
);

    logic [1:0]            c_sync;
    logic [1:0]            d_sync;
    logic [FILTER_LEN-1:0] filter_reg;
    logic                  filt_q;
    logic                  filt_next;

    always_comb begin
        // NOTE: default first so every path assigns filt_next and no latch is inferred.
        filt_next = filt_q;
        if (&filter_reg)
            filt_next = 1'b1;
        else if (~|filter_reg)
            filt_next = 1'b0;
    end

    // NOTE: all state here and in the receiver uses non-blocking assignments.
    always_ff @(posedge Clk_R) begin
        if (Reset_R) begin
            c_sync     <= '1;
            d_sync     <= '1;
            filter_reg <= '1;
            filt_q     <= 1'b1;
            fall_edge  <= 1'b0;
        end else begin
            c_sync     <= {c_sync[0], ps2c};
            d_sync     <= {d_sync[0], ps2d};
            filter_reg <= {filter_reg[FILTER_LEN-2:0], c_sync[1]};
            filt_q     <= filt_next;
            fall_edge  <= filt_q & ~filt_next;
        end
    end

    assign ps2d_sync = d_sync[1];

endmodule

// File: rtl/ps2_receptor.sv
// ---------------------------------------------------------------------------
// ps2_receptor
// PS/2 keyboard frame receiver: start, 8 data bits LSB first, odd parity,
// stop. Emits one scan-code byte per good frame with a one-cycle tick.
//   Clk_R    system clock (single domain)
//   Reset_R  synchronous active-high reset
//   ps2c     raw PS/2 clock line
//   ps2d     raw PS/2 data line
//   rx_if    ps2_receptor_if.master: rx_en in; dout, rx_done_tick, busy,
//            parity_err out
// Parity checking is selected by PS2_PARITY_CHECK_EN (see ps2_pkg).
// An in-progress frame is dropped silently after TIMEOUT_CYCLES without a
// clock edge, so a stalled keyboard cannot wedge the receiver.
// ---------------------------------------------------------------------------
module ps2_receptor
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic          Clk_R,
    input  logic          Reset_R,
    input  logic          ps2c,
    input  logic          ps2d,
    ps2_receptor_if.master rx_if
);

    localparam int              TW            = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);

    logic                      fall_edge;
    logic                      ps2d_sync;

    ps2_state_t                state;
    logic [PS2_FRAME_BITS-2:0] b;
    logic [3:0]                n;
    logic [TW-1:0]             timer;
    logic [7:0]                dout_q;
    logic                      tick_q;
    logic                      perr_q;

    ps2_clk_filtro #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filtro (
        .Clk_R     (Clk_R),
        .Reset_R   (Reset_R),
        .ps2c      (ps2c),
        .ps2d      (ps2d),
        .fall_edge (fall_edge),
        .ps2d_sync (ps2d_sync)
    );

    always_ff @(posedge Clk_R) begin
        if (Reset_R) begin
            state  <= IDLE;
            b      <= '0;
            n      <= '0;
            timer  <= '0;
            dout_q <= 8'h00;
            tick_q <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            perr_q <= 1'b0;
            case (state)
                IDLE: begin
                    // A high data line on an edge is noise, not a start bit.
                    if (fall_edge && rx_if.rx_en && !ps2d_sync) begin
                        b     <= '0;
                        n     <= 4'd9;
                        timer <= '0;
                        state <= DPS;
                    end
                end
                DPS: begin
                    if (fall_edge) begin
                        b     <= {ps2d_sync, b[PS2_FRAME_BITS-2:1]};
                        timer <= '0;
                        if (n == 4'd0)
                            state <= LOAD;
                        else
                            n <= n - 4'd1;
                    end else if (timer == TIMEOUT_LIMIT) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                LOAD: begin
                    if (ps2_frame_ok(b)) begin
                        dout_q <= b[7:0];
                        tick_q <= 1'b1;
                    end else begin
                        perr_q <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx_if.dout         = dout_q;
    assign rx_if.rx_done_tick = tick_q;
    assign rx_if.parity_err   = perr_q;
    assign rx_if.busy         = (state != IDLE);

endmodule
